// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one shared memory port, with a data-streak limit that keeps fetches from starving.
// Optional busy-cycle timeout abort is enabled by defining ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction; grant data or fetch this cycle
// I_BUSY | fetch transaction outstanding on the memory port
// D_BUSY | data load/store outstanding on the memory port
module mem_arbiter #(
  parameter int MAX_DSTREAK    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DSTREAK);

  state_t     state;
  logic [2:0] streak;
  logic       grant_d;

  // Data wins unless a fetch has already been held off for MAX_DSTREAK data grants.
  assign grant_d = d_req && !(i_req && (streak == STREAK_MAX));

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      err     <= 1'b0;
      tmo_cnt <= '0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= D_BUSY;
            m_req   <= 1'b1;
            m_addr  <= d_addr;
            m_write <= d_we;
            m_size  <= d_size;
            m_wdata <= d_wdata;
            if (!i_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 3'd1;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end else if (i_req) begin
            state   <= I_BUSY;
            m_req   <= 1'b1;
            m_addr  <= i_addr;
            m_write <= 1'b0;
            m_size  <= 2'b00;
            m_wdata <= '0;
            streak  <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end
        end
        I_BUSY, D_BUSY: begin
          if (!m_ack_n) begin
            state <= IDLE;
            m_req <= 1'b0;
            if (state == I_BUSY) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              if (!m_write)
                d_rdata <= m_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            state <= IDLE;
            m_req <= 1'b0;
            err   <= 1'b1;
            if (state == I_BUSY) begin
              i_rdata <= 32'hDEAD_BEEF;
              i_ack   <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              if (!m_write)
                d_rdata <= 32'hDEAD_BEEF;
            end
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level arbitration model.
// Covers the ARB_TIMEOUT_EN abort when that macro is defined, otherwise checks the indefinite wait.
module tb_mem_arbiter;
  localparam int MAX_DSTREAK    = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ack_n;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, m_req, m_write, err;
  logic [1:0]  m_size;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack_n(m_ack_n), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  // Memory side: stall lat cycles, then acknowledge once with data.
  task automatic serve(input int lat, input logic [31:0] data);
    for (int k = 0; k < lat; k++) begin
      m_ack_n = 1'b1;
      tick;
    end
    m_ack_n = 1'b0; m_rdata = data;
    tick;
    m_ack_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (m_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h55; d_addr = 32'h66;
    d_wdata = 32'h77; d_we = 1'b1; m_ack_n = 1'b0; m_rdata = 32'h99;
    tick; tick;
    checks++;
    if ({m_req, m_write, m_size, m_addr, m_wdata, i_ack, d_ack, err, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: m_req=%b m_write=%b m_size=%b m_addr=%h m_wdata=%h i_ack=%b d_ack=%b err=%b i_rdata=%h d_rdata=%h, all required 0",
               m_req, m_write, m_size, m_addr, m_wdata, i_ack, d_ack, err, i_rdata, d_rdata);
    end
    do_reset;
  endtask

  task automatic test_fetch;
    do_reset;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    tick;
    checks++;
    if ({m_req, m_addr, m_write, m_size} !== {1'b1, 32'h100, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL fetch_grant: m_req=%b m_addr=%h m_write=%b m_size=%b, required 1/00000100/0/00", m_req, m_addr, m_write, m_size);
    end
    serve(0, 32'h0000_0013);
    checks++;
    if ({i_ack, d_ack, m_req, err, i_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h13}) begin
      errors++;
      $display("FAIL fetch_done: i_ack=%b d_ack=%b m_req=%b err=%b i_rdata=%h, required 1/0/0/0/00000013", i_ack, d_ack, m_req, err, i_rdata);
    end
    i_req = 1'b0;
    tick;
    checks++;
    if ({i_ack, m_req, i_rdata} !== {1'b0, 1'b0, 32'h13}) begin
      errors++;
      $display("FAIL fetch_after: i_ack=%b m_req=%b i_rdata=%h, required 0/0/00000013", i_ack, m_req, i_rdata);
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h8000_0000;
    tick;
    checks++;
    if ({m_req, m_addr, m_write} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL simul_first_grant: m_req=%b m_addr=%h m_write=%b, required 1/80000000/0", m_req, m_addr, m_write);
    end
    serve(1, 32'hCAFE_0001);
    checks++;
    if ({d_ack, i_ack, d_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL simul_data_ack: d_ack=%b i_ack=%b d_rdata=%h, required 1/0/cafe0001", d_ack, i_ack, d_rdata);
    end
    d_req = 1'b0;
    tick;
    checks++;
    if ({m_req, m_addr, d_ack, i_ack} !== {1'b1, 32'h0000_0400, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_second_grant: m_req=%b m_addr=%h d_ack=%b i_ack=%b, required 1/00000400/0/0", m_req, m_addr, d_ack, i_ack);
    end
    serve(0, 32'hCAFE_0002);
    checks++;
    if ({i_ack, d_ack, i_rdata} !== {1'b1, 1'b0, 32'hCAFE_0002}) begin
      errors++;
      $display("FAIL simul_fetch_ack: i_ack=%b d_ack=%b i_rdata=%h, required 1/0/cafe0002", i_ack, d_ack, i_rdata);
    end
    i_req = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    bit ok;
    bit is_fetch;
    // D D D D then the fetch, then D again because the streak restarts.
    bit exp_fetch [6] = '{0, 0, 0, 0, 1, 0};
    do_reset;
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
    for (int g = 0; g < 6; g++) begin
      wait_req(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL starve_grant_timeout: grant %0d never seen, required m_req=1", g);
        break;
      end
      is_fetch = (m_addr === 32'h0000_1000);
      checks++;
      if (is_fetch !== exp_fetch[g]) begin
        errors++;
        $display("FAIL starve_order: grant %0d fetch=%b (m_addr=%h), required fetch=%b", g, is_fetch, m_addr, exp_fetch[g]);
      end
      serve(0, 32'(g));
    end
    i_req = 1'b0; d_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_byte_store;
    do_reset;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick;
    serve(0, 32'h1234_5678);
    d_req = 1'b0;
    checks++;
    if (d_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_preload: d_rdata=%h, required 12345678", d_rdata);
    end
    tick;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'hF000_0000; d_wdata = 32'h41;
    tick;
    checks++;
    if ({m_req, m_write, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h41}) begin
      errors++;
      $display("FAIL store_grant: m_req=%b m_write=%b m_size=%b m_addr=%h m_wdata=%h, required 1/1/10/f0000000/00000041",
               m_req, m_write, m_size, m_addr, m_wdata);
    end
    serve(1, 32'hFFFF_FFFF);
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL store_done: d_ack=%b d_rdata=%h, required 1/12345678", d_ack, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick;
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: m_req=%b, required 1", m_req);
    end
    tick;
    rst = 1'b1; m_ack_n = 1'b0; m_rdata = 32'hAAAA_5555;
    tick;
    checks++;
    if ({m_req, d_ack, d_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_in_reset: m_req=%b d_ack=%b d_rdata=%h, required 0/0/00000000", m_req, d_ack, d_rdata);
    end
    rst = 1'b0; m_ack_n = 1'b1; d_req = 1'b0;
    tick;
    checks++;
    if ({m_req, d_ack} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_after: m_req=%b d_ack=%b, required 0/0", m_req, d_ack);
    end
    i_req = 1'b1; i_addr = 32'h200;
    tick;
    checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rstmid_idle_regrant: m_req=%b m_addr=%h, required 1/00000200", m_req, m_addr);
    end
    serve(0, 32'h1);
    i_req = 1'b0;
    tick;
  endtask

  // Model: pending fetch/data requests; data wins unless the fetch has waited MAX_DSTREAK data grants.
  task automatic test_random;
    bit ip, dp, win_d, dwe, drop;
    logic [31:0] ia, da, dw, exp_ir, exp_dr, ea, rd;
    logic [1:0]  dsz, es;
    logic        ew;
    int          streak_m, lat;
    do_reset;
    ip = 0; dp = 0; streak_m = 0; exp_ir = '0; exp_dr = '0;
    for (int it = 0; it < 200; it++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom; i_addr = ia; i_req = 1'b1;
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1)); dsz = 2'($urandom_range(0, 3));
        d_addr = da; d_wdata = dw; d_we = dwe; d_size = dsz; d_req = 1'b1;
      end
      tick;
      if (!ip && !dp) begin
        checks++;
        if (m_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle: it=%0d m_req=%b, required 0", it, m_req);
        end
        continue;
      end
      win_d = dp && !(ip && streak_m == MAX_DSTREAK);
      if (win_d) begin
        if (!ip) streak_m = 0;
        else if (streak_m < MAX_DSTREAK) streak_m++;
        ea = da; ew = dwe; es = dsz;
      end else begin
        streak_m = 0;
        ea = ia; ew = 1'b0; es = 2'b00;
      end
      checks++;
      if ({m_req, m_addr, m_write, m_size} !== {1'b1, ea, ew, es}) begin
        errors++;
        $display("FAIL rand_grant: it=%0d m_req=%b m_addr=%h m_write=%b m_size=%b, required 1/%h/%b/%b",
                 it, m_req, m_addr, m_write, m_size, ea, ew, es);
      end
      if (win_d) begin
        checks++;
        if (m_wdata !== dw) begin
          errors++;
          $display("FAIL rand_wdata: it=%0d m_wdata=%h, required %h", it, m_wdata, dw);
        end
      end
      lat = $urandom_range(0, 4);
      drop = ($urandom_range(0, 3) == 0);
      if (drop) begin
        if (win_d) d_req = 1'b0; else i_req = 1'b0;
      end
      for (int k = 0; k < lat; k++) begin
        m_ack_n = 1'b1;
        tick;
        checks++;
        if ({m_req, m_addr, m_write, m_size, i_ack, d_ack} !== {1'b1, ea, ew, es, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rand_hold: it=%0d m_req=%b m_addr=%h m_write=%b m_size=%b i_ack=%b d_ack=%b, required 1/%h/%b/%b/0/0",
                   it, m_req, m_addr, m_write, m_size, i_ack, d_ack, ea, ew, es);
        end
      end
      rd = $urandom;
      m_ack_n = 1'b0; m_rdata = rd;
      tick;
      m_ack_n = 1'b1;
      if (win_d) begin
        if (!dwe) exp_dr = rd;
        dp = 0; d_req = 1'b0;
      end else begin
        exp_ir = rd;
        ip = 0; i_req = 1'b0;
      end
      checks++;
      if ({i_ack, d_ack, err, m_req, i_rdata, d_rdata} !== {!win_d, win_d, 1'b0, 1'b0, exp_ir, exp_dr}) begin
        errors++;
        $display("FAIL rand_done: it=%0d i_ack=%b d_ack=%b err=%b m_req=%b i_rdata=%h d_rdata=%h, required %b/%b/0/0/%h/%h",
                 it, i_ack, d_ack, err, m_req, i_rdata, d_rdata, !win_d, win_d, exp_ir, exp_dr);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick; tick;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    do_reset;
    i_req = 1'b1; i_addr = 32'h300;
    cnt = 0;
    tick;
    while (m_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick;
    end
    checks++;
    if (cnt != TIMEOUT_CYCLES) begin
      errors++;
      $display("FAIL timeout_busy_cycles: got %0d, required %0d", cnt, TIMEOUT_CYCLES);
    end
    checks++;
    if ({m_req, i_ack, d_ack, err, i_rdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL timeout_abort: m_req=%b i_ack=%b d_ack=%b err=%b i_rdata=%h, required 0/1/0/1/deadbeef", m_req, i_ack, d_ack, err, i_rdata);
    end
    i_req = 1'b0;
    tick;
    checks++;
    if ({i_ack, err} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_after: i_ack=%b err=%b, required 0/0", i_ack, err);
    end
  endtask
`else
  task automatic test_no_timeout;
    bit held;
    do_reset;
    i_req = 1'b1; i_addr = 32'h300;
    held = 1'b1;
    for (int k = 0; k < 3 * TIMEOUT_CYCLES; k++) begin
      tick;
      if (m_req !== 1'b1 || i_ack !== 1'b0 || err !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_wait: m_req=%b i_ack=%b err=%b, required m_req=1 i_ack=0 err=0 throughout", m_req, i_ack, err);
    end
    serve(0, 32'h7);
    checks++;
    if ({i_ack, err, i_rdata} !== {1'b1, 1'b0, 32'h7}) begin
      errors++;
      $display("FAIL no_timeout_done: i_ack=%b err=%b i_rdata=%h, required 1/0/00000007", i_ack, err, i_rdata);
    end
    i_req = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_fetch;
    test_simultaneous;
    test_starvation;
    test_byte_store;
    test_reset_mid;
    test_random;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: busy cycles without acknowledge before abort (ARB_TIMEOUT_EN only).
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
  clk      in   1   single clock, rising edge
  rst      in   1   synchronous reset, active-high
  i_req    in   1   fetch request, held until i_ack
  i_addr   in   32  fetch address
  i_rdata  out  32  fetched instruction word
  i_ack    out  1   fetch done, one-cycle pulse
  d_req    in   1   data request, held until d_ack
  d_we     in   1   1 = store, 0 = load
  d_size   in   2   00 word, 01 half, 1x byte
  d_addr   in   32  data address
  d_wdata  in   32  store data
  d_rdata  out  32  load data
  d_ack    out  1   data done, one-cycle pulse
  m_req    out  1   shared memory request (MREQ)
  m_write  out  1   shared memory write (WRITE)
  m_size   out  2   shared memory size (SIZE)
  m_addr   out  32  shared memory address
  m_wdata  out  32  shared memory write data
  m_rdata  in   32  shared memory read data
  m_ack_n  in   1   shared memory acknowledge, active-low
  err      out  1   timeout abort flag, valid with the ack pulse

Function
REQ-004 SHALL implement states IDLE, I_BUSY, D_BUSY.
REQ-005 In IDLE with d_req=1, SHALL move to D_BUSY, unless i_req=1 and the streak counter equals MAX_DSTREAK; in that case it SHALL move to I_BUSY.
REQ-006 In IDLE with only i_req=1, SHALL move to I_BUSY. With no request, SHALL stay in IDLE.
REQ-007 At grant, SHALL register m_addr, m_write, m_size and m_wdata from the granted requester and hold them constant through the whole transaction.
  - Fetch grants use m_write=0 and m_size=00.
REQ-008 SHALL drive m_req=1 exactly while in I_BUSY or D_BUSY.
  - Latency: request sampled in IDLE at edge N; m_req=1 from N+1.
REQ-009 In a busy state, when m_ack_n=0 is sampled, SHALL:
  - capture m_rdata into i_rdata or d_rdata (loads and fetches only);
  - pulse the matching ack for exactly one cycle starting the next cycle;
  - return to IDLE in that same cycle.
REQ-010 Back-to-back throughput SHALL be one new grant per IDLE cycle: m_req falls for at least one cycle between transactions.
REQ-011 i_rdata and d_rdata SHALL hold their value until the next capture. A store SHALL NOT modify d_rdata.
REQ-012 Deasserting a request mid-transaction SHALL NOT abort it; the ack is still pulsed.
REQ-013 Streak counter (3 bits, saturating at MAX_DSTREAK) SHALL:
  - increment on a data grant while i_req=1;
  - clear on a fetch grant, or on a data grant with i_req=0.
REQ-014 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-015 On rst=1 at a clock edge, SHALL force IDLE, streak=0 and timeout counter=0.
  - Outputs: m_req=0, m_write=0, m_size=00, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, err=0, i_rdata=0, d_rdata=0.
REQ-016 Reset during a busy state SHALL abandon the transaction with no ack pulse; m_ack_n arriving during reset SHALL be ignored.

Configuration
REQ-017 Macro ARB_TIMEOUT_EN defined: a counter SHALL count cycles in a busy state.
  - On reaching TIMEOUT_CYCLES without m_ack_n=0, SHALL return to IDLE and drop m_req.
  - SHALL pulse the requester's ack with err=1, and load rdata with 32'hDEAD_BEEF.
  - err SHALL be 0 on normal completion.
REQ-018 Macro ARB_TIMEOUT_EN undefined: the arbiter SHALL wait indefinitely for m_ack_n; err tied 0; no counter logic present.

Verification
REQ-019 Fetch only: i_req=1, i_addr=0x0000_0100; memory acks 1 cycle after m_req with 0x0000_0013 -> m_addr=0x100, m_write=0, i_rdata=0x13, i_ack one cycle.
REQ-020 Simultaneous: i_req=d_req=1 in IDLE, d_addr=0x8000_0000, load -> data granted first, then fetch; no overlapping acks.
REQ-021 Starvation: d_req held high with i_req=1, MAX_DSTREAK=4 -> exactly 4 data grants, then one fetch grant, streak cleared.
REQ-022 Byte store: d_we=1, d_size=10, d_addr=0xF000_0000, d_wdata=0x41 -> m_write=1, m_size=10, m_wdata=0x41; d_rdata unchanged.
REQ-023 Reset mid-transaction: rst=1 while in D_BUSY -> m_req=0 next edge, no d_ack, state IDLE.
REQ-024 ARB_TIMEOUT_EN defined, m_ack_n held 1 -> after 16 busy cycles: m_req=0, i_ack=1 with err=1, i_rdata=0xDEAD_BEEF.
